// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader for the instruction memory.
//
// Receives LEN_LO, LEN_HI (16-bit word count N) followed by 4*N data bytes,
// LSB first. It assembles 32-bit little-endian words and writes each one to
// imem at BASE_ADDR + 4*word_idx. The core is held in reset until the image
// is complete.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      1-cycle pulse; begins a load from IDLE, DONE or ERROR
//   in_valid   byte stream valid
//   in_data    byte stream data
//   in_ready   byte accepted when in_valid & in_ready
//   mem_we     imem write strobe, one cycle per word
//   mem_addr   imem byte address (word aligned)
//   mem_wdata  imem write data
//   cpu_reset  holds the core in reset while high
//   done       image loaded, core running
//   error      load aborted (length or checksum fault)
//
// Configuration
//   IMEM_LOADER_CHECKSUM_EN  when defined, one trailing byte must equal the
//                            XOR of all data bytes; otherwise there is no
//                            trailer.

module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM = 3'd6
`endif
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CSUM;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] word_idx_q, word_idx_d;
  // Only the lower three lanes are buffered; the fourth byte goes straight
  // into the write data register.
  logic [23:0] word_q, word_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        accept;
  logic        load_start;
  logic [15:0] len_full;

  assign in_ready = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    || (state_q == S_CSUM)
`endif
                    ;
  assign accept   = in_valid && in_ready;
  assign len_full = {in_data, len_q[7:0]};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    word_idx_d  = word_idx_q;
    word_d      = word_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;
    load_start  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        cpu_reset_d = 1'b1;
        if (start) load_start = 1'b1;
      end
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d[15:8] = in_data;
          if (len_full == 16'd0) begin
            state_d = S_FINISH;
          end else if ({16'd0, len_full} > MAX_WORDS) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: word_d[7:0]   = in_data;
            2'd1: word_d[15:8]  = in_data;
            2'd2: word_d[23:16] = in_data;
            default: begin
              mem_we_d    = 1'b1;
              mem_wdata_d = {in_data, word_q};
              mem_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
              word_idx_d  = word_idx_q + 16'd1;
              // Leaving DATA here still lets the registered write land in
              // the next cycle; done only rises one cycle after that.
              if (word_idx_q == len_q - 16'd1) state_d = S_FINISH;
            end
          endcase
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
`endif
      S_DONE: begin
        if (start) begin
          load_start = 1'b1;
        end else begin
          done_d      = 1'b1;
          cpu_reset_d = 1'b0;
        end
      end
      S_ERROR: begin
        error_d     = 1'b1;
        cpu_reset_d = 1'b1;
        if (start) load_start = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (load_start) begin
      state_d     = S_LEN0;
      len_d       = '0;
      byte_cnt_d  = '0;
      word_idx_d  = '0;
      word_d      = '0;
      cpu_reset_d = 1'b1;
      done_d      = 1'b0;
      error_d     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d      = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      word_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      word_idx_q  <= word_idx_d;
      word_q      <= word_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (BASE_ADDR=0, MAX_WORDS=64).
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_loader #(
    .BASE_ADDR(32'h0000_0000),
    .MAX_WORDS(64)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .done     (done),
    .error    (error)
  );

  // Write recorder: every strobe seen on a falling edge is logged.
  int          we_cnt = 0;
  logic [31:0] wr_addr [0:15];
  logic [31:0] wr_data [0:15];
  logic        overlap = 1'b0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (we_cnt < 16) begin
        wr_addr[we_cnt] <= mem_addr;
        wr_data[we_cnt] <= mem_wdata;
      end
      we_cnt <= we_cnt + 1;
      if (done === 1'b1) overlap <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("ready_wait", (n < 20), 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("start_ready", in_ready, 1'b1);
    chk1("start_done", done, 1'b0);
    chk1("start_error", error, 1'b0);
    chk1("start_cpu_reset", cpu_reset, 1'b1);
  endtask

  // Two-word image: 0x00500093 @0x0, 0x00A00113 @0x4. Ends just after the
  // final data byte is taken and checks the write-back cycle of word 1.
  task automatic send_image(input int gap);
    logic [7:0] img [0:9];
    img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    for (int i = 0; i < 10; i++) send_byte(img[i], gap);
    @(negedge clk);
    chk1("last_we", mem_we, 1'b1);
    chk("last_addr", mem_addr, 32'h0000_0004);
    chk("last_wdata", mem_wdata, 32'h00A0_0113);
    chk1("last_we_no_done", done, 1'b0);
  endtask

  task automatic check_writes(input int base);
    @(negedge clk);
    chk("we_count", 32'(we_cnt - base), 32'd2);
    chk("w0_addr", wr_addr[base], 32'h0000_0000);
    chk("w0_data", wr_data[base], 32'h0050_0093);
    chk("w1_addr", wr_addr[base + 1], 32'h0000_0004);
    chk("w1_data", wr_data[base + 1], 32'h00A0_0113);
  endtask

  // Final step of a good image; done must rise exactly one cycle after the
  // last accepted byte (the final write strobe or the checksum trailer).
  task automatic finish_ok(input int gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h71, gap);   // 93^50^13^01^A0 = 71
    @(negedge clk);
    chk1("csum_done_lag", done, 1'b0);
`endif
    @(negedge clk);
    chk1("done_rise", done, 1'b1);
    chk1("done_cpu_reset", cpu_reset, 1'b0);
    chk1("done_no_we", mem_we, 1'b0);
    chk1("done_ready", in_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst_ready", in_ready, 1'b0);
    chk1("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk1("rst_cpu_reset", cpu_reset, 1'b1);
    chk1("rst_done", done, 1'b0);
    chk1("rst_error", error, 1'b0);
    reset = 1'b0;

    // 1: idle without start
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_hold", 32'({cpu_reset, in_ready, mem_we}), 32'h4);
    end

    // 2: two-word image, back-to-back bytes
    base = we_cnt;
    pulse_start();
    send_image(0);
    finish_ok(0);
    check_writes(base);

    // 3: same image with in_valid low every other cycle
    base = we_cnt;
    pulse_start();
    send_image(1);
    finish_ok(1);
    check_writes(base);

    // 4: length 65 > MAX_WORDS -> error, no writes
    base = we_cnt;
    pulse_start();
    send_byte(8'h41, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    chk1("len_err_error", error, 1'b1);
    chk1("len_err_ready", in_ready, 1'b0);
    chk1("len_err_cpu_reset", cpu_reset, 1'b1);
    chk1("len_err_done", done, 1'b0);
    repeat (5) @(negedge clk);
    chk("len_err_no_we", 32'(we_cnt - base), 32'd0);
    chk1("len_err_sticky", error, 1'b1);

    // Length exactly MAX_WORDS is accepted; then reset in the middle of DATA
    pulse_start();
    send_byte(8'h40, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    chk1("len_max_ready", in_ready, 1'b1);
    chk1("len_max_error", error, 1'b0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    @(negedge clk);
    chk1("max_w0_we", mem_we, 1'b1);
    chk("max_w0_addr", mem_addr, 32'h0);
    chk("max_w0_data", mem_wdata, 32'h4433_2211);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk1("midrst_ready", in_ready, 1'b0);
    chk1("midrst_cpu_reset", cpu_reset, 1'b1);
    chk1("midrst_we", mem_we, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk("midrst_addr", mem_addr, 32'h0);
    repeat (3) @(negedge clk);
    chk1("midrst_idle_ready", in_ready, 1'b0);

    // 5: zero-length image
    base = we_cnt;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    n = 0;
    while (done !== 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk1("zero_len_done", done, 1'b1);
    chk1("zero_len_cpu_reset", cpu_reset, 1'b0);
    chk("zero_len_no_we", 32'(we_cnt - base), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 6: bad trailer -> error, words stay written; then a good image
    base = we_cnt;
    pulse_start();
    send_image(0);
    send_byte(8'h70, 0);
    @(negedge clk);
    chk1("csum_bad_error", error, 1'b1);
    chk1("csum_bad_cpu_reset", cpu_reset, 1'b1);
    chk1("csum_bad_done", done, 1'b0);
    check_writes(base);
    base = we_cnt;
    pulse_start();
    send_image(0);
    finish_ok(0);
    check_writes(base);
`endif

    repeat (2) @(negedge clk);
    chk1("we_done_overlap", overlap, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
